// File: rtl/load_store_unit.sv
// load_store_unit: data-side access unit between the core control FSM and the
// data port of the unified memory. Accepts one request at a time, issues a
// word-aligned access with byte strobes, extends load data and reports
// misaligned or unsupported accesses without touching memory.
module load_store_unit #(
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_WAIT = 2'd1,
    STORE     = 2'd2,
    RESP      = 2'd3
  } state_t;

  // Final value of the wait counter; the memory needs READ_LATENCY edges after
  // mem_addr settles, plus one edge to sample mem_rdata.
  localparam logic [1:0] LAT_C = 2'(READ_LATENCY);

  state_t      state_r;
  state_t      state_s;
  logic [1:0]  cnt_r;
  logic [1:0]  cnt_s;
  logic [2:0]  funct3_r;
  logic [2:0]  funct3_s;
  logic [1:0]  off_r;
  logic [1:0]  off_s;
  logic        resp_valid_s;
  logic        resp_error_s;
  logic [31:0] resp_rdata_s;
  logic [31:0] mem_addr_s;
  logic        mem_we_s;
  logic [3:0]  mem_wstrb_s;
  logic [31:0] mem_wdata_s;
  logic        legal_s;

  // Checks funct3 against the access direction and the address alignment.
  function automatic logic access_legal(input logic wr, input logic [2:0] f3,
                                        input logic [1:0] off);
    logic ok;
    if (wr) begin
      case (f3)
        3'b000:  ok = 1'b1;
        3'b001:  ok = ~off[0];
        3'b010:  ok = (off == 2'b00);
        default: ok = 1'b0;
      endcase
    end else begin
      case (f3)
        3'b000, 3'b100: ok = 1'b1;
        3'b001, 3'b101: ok = ~off[0];
        3'b010:         ok = (off == 2'b00);
        default:        ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

  // Picks the addressed lane(s) from the memory word and extends the result.
  function automatic logic [31:0] load_extend(input logic [2:0] f3,
                                              input logic [1:0] off,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'b00:   b = word[7:0];
      2'b01:   b = word[15:8];
      2'b10:   b = word[23:16];
      2'b11:   b = word[31:24];
      default: b = 8'h00;
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b010:  r = word;
      3'b100:  r = {24'h000000, b};
      3'b101:  r = {16'h0000, h};
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  // Replicates byte / halfword store data so every candidate lane carries it.
  function automatic logic [31:0] store_lanes(input logic [2:0] f3,
                                              input logic [31:0] d);
    logic [31:0] r;
    case (f3)
      3'b000:  r = {4{d[7:0]}};
      3'b001:  r = {2{d[15:0]}};
      3'b010:  r = d;
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  // Byte-lane enables for a store of the given size at the given offset.
  function automatic logic [3:0] store_strb(input logic [2:0] f3,
                                            input logic [1:0] off);
    logic [3:0] r;
    case (f3)
      3'b000:  r = 4'b0001 << off;
      3'b001:  r = 4'b0011 << {off[1], 1'b0};
      3'b010:  r = 4'b1111;
      default: r = 4'b0000;
    endcase
    return r;
  endfunction

  assign req_ready = (state_r == IDLE);
  assign legal_s   = access_legal(req_write, req_funct3, req_addr[1:0]);

  // Next-state and next-output logic; all outputs are registered below.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    funct3_s     = funct3_r;
    off_s        = off_r;
    resp_valid_s = 1'b0;
    resp_error_s = 1'b0;
    resp_rdata_s = 32'h0000_0000;
    mem_addr_s   = mem_addr;
    mem_we_s     = 1'b0;
    mem_wstrb_s  = 4'b0000;
    mem_wdata_s  = mem_wdata;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          funct3_s = req_funct3;
          off_s    = req_addr[1:0];
          if (!legal_s) begin
            // Rejected accesses never reach memory and keep mem_addr.
            state_s      = RESP;
            resp_valid_s = 1'b1;
            resp_error_s = 1'b1;
          end else if (req_write) begin
            state_s     = STORE;
            mem_addr_s  = {req_addr[31:2], 2'b00};
            mem_we_s    = 1'b1;
            mem_wstrb_s = store_strb(req_funct3, req_addr[1:0]);
            mem_wdata_s = store_lanes(req_funct3, req_wdata);
          end else begin
            state_s    = LOAD_WAIT;
            mem_addr_s = {req_addr[31:2], 2'b00};
            cnt_s      = 2'd0;
          end
        end else begin
          state_s = IDLE;
        end
      end
      LOAD_WAIT: begin
        if (cnt_r == LAT_C) begin
          state_s      = RESP;
          resp_valid_s = 1'b1;
          resp_rdata_s = load_extend(funct3_r, off_r, mem_rdata);
          cnt_s        = 2'd0;
        end else begin
          cnt_s = cnt_r + 2'd1;
        end
      end
      STORE: begin
        state_s      = RESP;
        resp_valid_s = 1'b1;
      end
      RESP: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // FSM state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Registered outputs and request context; reset drops any in-flight access.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r      <= 2'd0;
      funct3_r   <= 3'b000;
      off_r      <= 2'b00;
      resp_valid <= 1'b0;
      resp_error <= 1'b0;
      resp_rdata <= 32'h0000_0000;
      mem_addr   <= 32'h0000_0000;
      mem_we     <= 1'b0;
      mem_wstrb  <= 4'b0000;
      mem_wdata  <= 32'h0000_0000;
    end else begin
      cnt_r      <= cnt_s;
      funct3_r   <= funct3_s;
      off_r      <= off_s;
      resp_valid <= resp_valid_s;
      resp_error <= resp_error_s;
      resp_rdata <= resp_rdata_s;
      mem_addr   <= mem_addr_s;
      mem_we     <= mem_we_s;
      mem_wstrb  <= mem_wstrb_s;
      mem_wdata  <= mem_wdata_s;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: table-driven requests checked through a
// response scoreboard, plus hand sequences for back-to-back handshakes,
// READ_LATENCY=3 and reset in the middle of a store or a load.
module tb_load_store_unit;

  typedef struct {
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [3:0]  exp_strb;
    logic [31:0] exp_mwdata;
    logic [31:0] exp_maddr;
    int          exp_lat;
  } vec_t;

  typedef struct {
    vec_t v;
    int   acc;
  } sb_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;

  logic        b_req_valid = 1'b0;
  logic        b_req_ready;
  logic        b_resp_valid;
  logic [31:0] b_resp_rdata;
  logic        b_resp_error;
  logic [31:0] b_mem_addr;
  logic        b_mem_we;
  logic [3:0]  b_mem_wstrb;
  logic [31:0] b_mem_wdata;
  logic [31:0] b_mem_rdata = 32'h0;
  logic [31:0] p0 = 32'h0;
  logic [31:0] p1 = 32'h0;

  logic [31:0] mem [0:127];

  int passed = 0;
  int total = 0;
  int cyc = 0;
  int acc_cnt = 0;
  int resp_cnt = 0;
  logic [31:0] last_maddr = 32'h0;
  vec_t cur;
  vec_t tbl[$];
  sb_t  sb[$];
  vec_t st_q[$];

  load_store_unit #(.READ_LATENCY(1)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_error(resp_error), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  load_store_unit #(.READ_LATENCY(3)) dut_l3 (
    .clk(clk), .reset(reset), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_write(1'b0), .req_funct3(3'b010), .req_addr(32'h0000_0100),
    .req_wdata(32'h0), .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata),
    .resp_error(b_resp_error), .mem_addr(b_mem_addr), .mem_we(b_mem_we),
    .mem_wstrb(b_mem_wstrb), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory models: one-edge read for dut, three-edge read pipeline for dut_l3.
  always @(posedge clk) begin
    mem_rdata <= mem[mem_addr[8:2]];
    p0 <= mem[b_mem_addr[8:2]];
    p1 <= p0;
    b_mem_rdata <= p1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] rd, input logic err,
                              input logic [3:0] strb, input logic [31:0] mwd, input int lat);
    vec_t v;
    v.wr = wr; v.f3 = f3; v.addr = a; v.wdata = wd; v.exp_rdata = rd; v.exp_err = err;
    v.exp_strb = strb; v.exp_mwdata = mwd; v.exp_maddr = {a[31:2], 2'b00}; v.exp_lat = lat;
    return v;
  endfunction

  // Accept monitor: pushes the driven request when the handshake completes.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (!reset && req_valid && req_ready) begin
        acc_cnt++;
        sb.push_back('{cur, cyc});
        if (cur.wr && !cur.exp_err) st_q.push_back(cur);
      end
    end
  end

  // Output monitor: compares responses and store beats against the scoreboard.
  initial begin
    sb_t e;
    vec_t s;
    forever begin
      @(negedge clk);
      if (resp_valid) begin
        resp_cnt++;
        if (sb.size() == 0) begin
          check("resp_unexpected", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("resp_rdata", resp_rdata, e.v.exp_rdata);
          check("resp_error", {31'd0, resp_error}, {31'd0, e.v.exp_err});
          check("resp_latency", 32'(cyc - e.acc), 32'(e.v.exp_lat));
          if (e.v.exp_err) begin
            check("err_mem_addr_held", mem_addr, last_maddr);
          end else begin
            check("mem_addr", mem_addr, e.v.exp_maddr);
            last_maddr = e.v.exp_maddr;
          end
        end
      end
      if (mem_we) begin
        if (st_q.size() == 0) begin
          check("mem_we_unexpected", 32'd1, 32'd0);
        end else begin
          s = st_q.pop_front();
          check("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, s.exp_strb});
          check("mem_wdata", mem_wdata, s.exp_mwdata);
          check("store_mem_addr", mem_addr, s.exp_maddr);
        end
      end
    end
  end

  task automatic drive(input vec_t v);
    cur = v;
    req_write = v.wr;
    req_funct3 = v.f3;
    req_addr = v.addr;
    req_wdata = v.wdata;
    req_valid = 1'b1;
  endtask

  task automatic wait_accept(input int start);
    bit ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (acc_cnt != start) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("accept_timeout", 32'd1, 32'd0);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    check("drain", 32'(sb.size()), 32'd0);
    @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    drive(v);
    wait_accept(acc_cnt);
    req_valid = 1'b0;
    drain();
  endtask

  initial begin
    int k;
    int r0;
    int a0;
    for (int i = 0; i < 128; i++) mem[i] = 32'h0;
    mem[64] = 32'h8899_AABB;
    mem[65] = 32'h7F80_0180;
    cur = mk(1'b0, 3'b010, 32'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 2);

    // loads: wr f3 addr wdata rdata err strb mwdata lat
    tbl.push_back(mk(1'b0, 3'b010, 32'h100, 32'h0, 32'h8899AABB, 1'b0, 4'h0, 32'h0, 2));
    tbl.push_back(mk(1'b0, 3'b000, 32'h103, 32'h0, 32'hFFFFFF88, 1'b0, 4'h0, 32'h0, 2));
    tbl.push_back(mk(1'b0, 3'b100, 32'h103, 32'h0, 32'h00000088, 1'b0, 4'h0, 32'h0, 2));
    tbl.push_back(mk(1'b0, 3'b001, 32'h100, 32'h0, 32'hFFFFAABB, 1'b0, 4'h0, 32'h0, 2));
    tbl.push_back(mk(1'b0, 3'b101, 32'h102, 32'h0, 32'h00008899, 1'b0, 4'h0, 32'h0, 2));
    tbl.push_back(mk(1'b0, 3'b000, 32'h100, 32'h0, 32'hFFFFFFBB, 1'b0, 4'h0, 32'h0, 2));
    tbl.push_back(mk(1'b0, 3'b100, 32'h101, 32'h0, 32'h000000AA, 1'b0, 4'h0, 32'h0, 2));
    tbl.push_back(mk(1'b0, 3'b001, 32'h104, 32'h0, 32'h00000180, 1'b0, 4'h0, 32'h0, 2));
    tbl.push_back(mk(1'b0, 3'b001, 32'h106, 32'h0, 32'h00007F80, 1'b0, 4'h0, 32'h0, 2));
    tbl.push_back(mk(1'b0, 3'b000, 32'h106, 32'h0, 32'hFFFFFF80, 1'b0, 4'h0, 32'h0, 2));
    // stores
    tbl.push_back(mk(1'b1, 3'b000, 32'h101, 32'h123456CD, 32'h0, 1'b0, 4'b0010, 32'hCDCDCDCD, 1));
    tbl.push_back(mk(1'b1, 3'b001, 32'h102, 32'h0000BEEF, 32'h0, 1'b0, 4'b1100, 32'hBEEFBEEF, 1));
    tbl.push_back(mk(1'b1, 3'b010, 32'h104, 32'hDEADBEEF, 32'h0, 1'b0, 4'b1111, 32'hDEADBEEF, 1));
    tbl.push_back(mk(1'b1, 3'b000, 32'h107, 32'h000000A5, 32'h0, 1'b0, 4'b1000, 32'hA5A5A5A5, 1));
    tbl.push_back(mk(1'b1, 3'b001, 32'h104, 32'hCAFE1234, 32'h0, 1'b0, 4'b0011, 32'h12341234, 1));
    // errors
    tbl.push_back(mk(1'b0, 3'b010, 32'h102, 32'h0, 32'h0, 1'b1, 4'h0, 32'h0, 0));
    tbl.push_back(mk(1'b1, 3'b001, 32'h105, 32'h0000BEEF, 32'h0, 1'b1, 4'h0, 32'h0, 0));
    tbl.push_back(mk(1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 1'b1, 4'h0, 32'h0, 0));
    tbl.push_back(mk(1'b1, 3'b100, 32'h100, 32'h11111111, 32'h0, 1'b1, 4'h0, 32'h0, 0));
    tbl.push_back(mk(1'b0, 3'b001, 32'h101, 32'h0, 32'h0, 1'b1, 4'h0, 32'h0, 0));
    tbl.push_back(mk(1'b0, 3'b110, 32'h100, 32'h0, 32'h0, 1'b1, 4'h0, 32'h0, 0));
    tbl.push_back(mk(1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 1'b1, 4'h0, 32'h0, 0));

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_error", {31'd0, resp_error}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);

    foreach (tbl[i]) run_vec(tbl[i]);

    // back-to-back: req_valid held high across three loads
    r0 = resp_cnt;
    a0 = acc_cnt;
    @(negedge clk);
    drive(tbl[0]);
    for (int j = 0; j < 3; j++) begin
      wait_accept(acc_cnt);
      check("busy_req_ready", {31'd0, req_ready}, 32'd0);
      if (j == 0) drive(tbl[4]);
      else if (j == 1) drive(tbl[1]);
      else req_valid = 1'b0;
    end
    drain();
    repeat (4) @(negedge clk);
    check("b2b_accepts", 32'(acc_cnt - a0), 32'd3);
    check("b2b_responses", 32'(resp_cnt - r0), 32'd3);

    // READ_LATENCY=3 word load: response 4 cycles after accept
    @(negedge clk);
    b_req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b_req_valid = 1'b0;
    k = 0;
    for (int i = 1; i <= 12; i++) begin
      if (b_resp_valid) begin
        k = i;
        break;
      end
      @(negedge clk);
    end
    check("l3_latency", 32'(k - 1), 32'd4);
    check("l3_rdata", b_resp_rdata, 32'h8899AABB);
    check("l3_error", {31'd0, b_resp_error}, 32'd0);
    check("l3_mem_we", {31'd0, b_mem_we}, 32'd0);
    check("l3_mem_addr", b_mem_addr, 32'h100);
    @(negedge clk);
    check("l3_resp_pulse", {31'd0, b_resp_valid}, 32'd0);
    check("l3_wstrb_wdata", {28'd0, b_mem_wstrb} | b_mem_wdata, 32'd0);

    // reset during STORE
    r0 = resp_cnt;
    @(negedge clk);
    drive(mk(1'b1, 3'b010, 32'h108, 32'h0BADF00D, 32'h0, 1'b0, 4'b1111, 32'h0BADF00D, 1));
    wait_accept(acc_cnt);
    req_valid = 1'b0;
    check("rst_store_we_before", {31'd0, mem_we}, 32'd1);
    reset = 1'b1;
    sb.delete();
    @(negedge clk);
    check("rst_store_we_after", {31'd0, mem_we}, 32'd0);
    check("rst_store_resp", {31'd0, resp_valid}, 32'd0);
    reset = 1'b0;
    last_maddr = 32'h0;
    repeat (4) @(negedge clk);
    check("rst_store_no_resp", 32'(resp_cnt - r0), 32'd0);

    // reset during LOAD_WAIT
    r0 = resp_cnt;
    @(negedge clk);
    drive(tbl[0]);
    wait_accept(acc_cnt);
    req_valid = 1'b0;
    reset = 1'b1;
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_load_req_ready", {31'd0, req_ready}, 32'd1);
    last_maddr = 32'h0;
    repeat (4) @(negedge clk);
    check("rst_load_no_resp", 32'(resp_cnt - r0), 32'd0);

    // unit recovers after reset
    run_vec(tbl[1]);
    run_vec(tbl[10]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
